// File: rtl/id_ex_skid_pkg.sv
// rtl/id_ex_skid_pkg.sv - shared constants and skid state encoding for the ID/EX stage
package id_ex_skid_pkg;

    localparam logic [7:0]  EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [2:0]  EXE_RES_NOP  = 3'b000;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic        WriteDisable = 1'b0;
    localparam logic        RstEnable    = 1'b1;

    // Encoding doubles as the entry count exported on occupancy.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/id_ex_skid_skid_buf.sv
// rtl/id_ex_skid_skid_buf.sv - generic 2-entry valid/ready skid buffer with registered in_ready and flush
module skid_buf
    import id_ex_skid_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic [1:0]   occupancy_o
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] m_q, m_d;
    logic [W-1:0] s_q, s_d;
    logic         ready_q, ready_d;
    logic         accept;
    logic         pop;

    assign accept = in_valid_i & ready_q;
    assign pop    = (state_q != SKID_EMPTY) & out_ready_i;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        if (flush_i) begin
            // Stale payload bits are left in place; the state alone marks them dead.
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (accept) begin
                        state_d = SKID_ONE;
                        m_d     = in_data_i;
                    end
                end
                SKID_ONE: begin
                    if (accept && pop) begin
                        m_d = in_data_i;
                    end else if (accept) begin
                        state_d = SKID_FULL;
                        s_d     = in_data_i;
                    end else if (pop) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (pop) begin
                        state_d = SKID_ONE;
                        m_d     = s_q;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
        ready_d = (state_d != SKID_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= SKID_EMPTY;
            m_q     <= '0;
            s_q     <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
            ready_q <= ready_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = (state_q != SKID_EMPTY);
    assign out_data_o  = m_q;
    assign occupancy_o = state_q;

endmodule

// File: rtl/id_ex_skid.sv
// rtl/id_ex_skid.sv - ID/EX pipeline register with valid/ready handshake, skid buffer and flush
module id_ex_skid
    import id_ex_skid_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [ALUOP_W-1:0]  id_aluop,
    input  logic [ALUSEL_W-1:0] id_alusel,
    input  logic [DATA_W-1:0]   id_reg1,
    input  logic [DATA_W-1:0]   id_reg2,
    input  logic [ADDR_W-1:0]   id_wd,
    input  logic                id_wreg,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [ALUOP_W-1:0]  ex_aluop,
    output logic [ALUSEL_W-1:0] ex_alusel,
    output logic [DATA_W-1:0]   ex_reg1,
    output logic [DATA_W-1:0]   ex_reg2,
    output logic [ADDR_W-1:0]   ex_wd,
    output logic                ex_wreg,
    output logic [1:0]          occupancy
);

    localparam int W = ALUOP_W + ALUSEL_W + 2 * DATA_W + ADDR_W + 1;

    logic [W-1:0] in_bundle;
    logic [W-1:0] out_bundle;
    logic [W-1:0] nop_bundle;
    logic [W-1:0] ex_bundle;

    assign in_bundle  = {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg};
    assign nop_bundle = {ALUOP_W'(EXE_NOP_OP), ALUSEL_W'(EXE_RES_NOP), DATA_W'(ZeroWord),
                         DATA_W'(ZeroWord), ADDR_W'(0), WriteDisable};

    skid_buf #(
        .W(W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_valid_i  (id_valid),
        .in_ready_o  (id_ready),
        .in_data_i   (in_bundle),
        .out_valid_o (ex_valid),
        .out_ready_i (ex_ready),
        .out_data_o  (out_bundle),
        .occupancy_o (occupancy)
    );

    // Bubbles must never reach the register file, so the payload is masked rather than left stale.
    assign ex_bundle = ex_valid ? out_bundle : nop_bundle;
    assign {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg} = ex_bundle;

endmodule

// File: tb/tb_id_ex_skid.sv
// tb/tb_id_ex_skid.sv - scoreboard testbench for id_ex_skid
module tb_id_ex_skid;

    localparam int W = 8 + 3 + 32 + 32 + 5 + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic        id_ready;
    logic [7:0]  id_aluop = '0;
    logic [2:0]  id_alusel = '0;
    logic [31:0] id_reg1 = '0;
    logic [31:0] id_reg2 = '0;
    logic [4:0]  id_wd = '0;
    logic        id_wreg = 1'b0;
    logic        ex_valid;
    logic        ex_ready = 1'b0;
    logic [7:0]  ex_aluop;
    logic [2:0]  ex_alusel;
    logic [31:0] ex_reg1;
    logic [31:0] ex_reg2;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;
    bit started = 0;
    logic [W-1:0] sb_q[$];
    logic [4:0]   got_wd[$];

    id_ex_skid dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_aluop(id_aluop), .id_alusel(id_alusel), .id_reg1(id_reg1),
        .id_reg2(id_reg2), .id_wd(id_wd), .id_wreg(id_wreg),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_aluop(ex_aluop), .ex_alusel(ex_alusel), .ex_reg1(ex_reg1),
        .ex_reg2(ex_reg2), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [4:0] wd, input logic [31:0] r1);
        id_valid  = v;
        id_aluop  = 8'h20 | {3'b0, wd};
        id_alusel = wd[2:0] ^ 3'b101;
        id_reg1   = r1;
        id_reg2   = ~r1;
        id_wd     = wd;
        id_wreg   = 1'b1;
    endtask

    task automatic expect_seq(input string name, input int n,
                              input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        chk({name, "_count"}, got_wd.size(), n);
        for (int i = 0; i < n && i < got_wd.size(); i++)
            chk({name, "_wd"}, got_wd[i], e[i]);
    endtask

    // Monitor: compares the DUT against the scoreboard each cycle, then applies this cycle's events.
    always @(negedge clk) begin
        logic [W-1:0] exp_b;
        if (started) begin
            chk("occupancy", occupancy, sb_q.size());
            chk("id_ready", id_ready, sb_q.size() < 2);
            chk("ex_valid", ex_valid, sb_q.size() != 0);
            if (!ex_valid)
                chk("bubble", {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg}, 0);
            if (rst) begin
                sb_q.delete();
            end else begin
                if (ex_valid && ex_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_pop", 1, 0);
                    end else begin
                        exp_b = sb_q.pop_front();
                        chk("payload", {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg}, exp_b);
                        got_wd.push_back(ex_wd);
                    end
                end
                if (flush)
                    sb_q.delete();
                else if (id_valid && id_ready)
                    sb_q.push_back({id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg});
            end
        end
    end

    initial begin
        // Reset held for 3 cycles with a live-looking input.
        drive(1, 5'd9, 32'h1234_5678);
        rst = 1'b1;
        @(posedge clk);
        #1;
        started = 1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_ex_valid", ex_valid, 0);
            chk("rst_ex_reg1", ex_reg1, 0);
            chk("rst_ex_wreg", ex_wreg, 0);
            chk("rst_id_ready", id_ready, 1);
            chk("rst_occupancy", occupancy, 0);
            step();
        end
        rst = 1'b0;
        id_valid = 1'b0;
        step();

        // Streaming at full rate: each instruction visible one edge after its accept.
        got_wd.delete();
        ex_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 5'(i + 1), 32'hA0 + i);
            step();
            chk("stream_ex_valid", ex_valid, 1);
            chk("stream_ex_wd", ex_wd, i + 1);
            chk("stream_ex_reg1", ex_reg1, 32'hA0 + i);
            chk("stream_occupancy", occupancy, 1);
        end
        id_valid = 1'b0;
        step();
        step();
        expect_seq("stream", 4, 1, 2, 3, 4);

        // Stall: M then S fill, third offer waits until the skid drains.
        got_wd.delete();
        ex_ready = 1'b0;
        drive(1, 5'd1, 32'hB1);
        step();
        drive(1, 5'd2, 32'hB2);
        step();
        drive(1, 5'd3, 32'hB3);
        chk("stall_occupancy", occupancy, 2);
        chk("stall_id_ready", id_ready, 0);
        chk("stall_ex_wd", ex_wd, 1);
        step();
        step();
        chk("stall_hold_occupancy", occupancy, 2);
        chk("stall_hold_ex_wd", ex_wd, 1);
        ex_ready = 1'b1;
        step();
        chk("release_ex_wd", ex_wd, 2);
        chk("release_id_ready", id_ready, 1);
        step();
        id_valid = 1'b0;
        chk("release_third_ex_wd", ex_wd, 3);
        step();
        step();
        expect_seq("stall", 3, 1, 2, 3, 0);

        // Flush while FULL with an offer pending.
        got_wd.delete();
        ex_ready = 1'b0;
        drive(1, 5'd5, 32'hC5);
        step();
        drive(1, 5'd6, 32'hC6);
        step();
        chk("flush_pre_occupancy", occupancy, 2);
        drive(1, 5'd7, 32'hC7);
        flush = 1'b1;
        step();
        flush = 1'b0;
        id_valid = 1'b0;
        chk("flush_ex_valid", ex_valid, 0);
        chk("flush_ex_wreg", ex_wreg, 0);
        chk("flush_ex_wd", ex_wd, 0);
        chk("flush_occupancy", occupancy, 0);
        chk("flush_id_ready", id_ready, 1);
        ex_ready = 1'b1;
        step();
        step();
        expect_seq("flush", 0, 0, 0, 0, 0);

        // Flush coincident with a pop: the popped one counts, the incoming one is dropped.
        got_wd.delete();
        drive(1, 5'd8, 32'hD8);
        step();
        drive(1, 5'd9, 32'hD9);
        flush = 1'b1;
        step();
        flush = 1'b0;
        id_valid = 1'b0;
        chk("flushpop_occupancy", occupancy, 0);
        chk("flushpop_ex_valid", ex_valid, 0);
        step();
        step();
        expect_seq("flushpop", 1, 8, 0, 0, 0);

        // Reset mid-operation drops everything.
        ex_ready = 1'b0;
        drive(1, 5'd10, 32'hE0);
        step();
        drive(1, 5'd11, 32'hE1);
        step();
        id_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_occupancy", occupancy, 0);
        chk("midrst_ex_wreg", ex_wreg, 0);
        chk("midrst_id_ready", id_ready, 1);
        step();

        // Random traffic against the scoreboard.
        for (int i = 0; i < 10000; i++) begin
            id_valid  = $urandom_range(0, 1);
            id_aluop  = 8'($urandom);
            id_alusel = 3'($urandom);
            id_reg1   = $urandom;
            id_reg2   = $urandom;
            id_wd     = 5'($urandom);
            id_wreg   = 1'($urandom);
            ex_ready  = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            step();
        end
        id_valid = 1'b0;
        flush = 1'b0;
        ex_ready = 1'b1;
        step();
        step();
        step();
        chk("drain_occupancy", occupancy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
